// File: rtl/gamerom_loader_if.sv
// Stream-in / ROM-load-port bundle for the game ROM loader.
// The master modport is the loader itself; slave is the SPI-side/ROM-side environment.
interface gamerom_loader_if #(
   parameter int ADDR_BITS = 16
) ();
   logic                 in_valid;
   logic [7:0]           in_data;
   logic                 in_ready;
   logic                 we_b;
   logic [ADDR_BITS-1:0] addr_b;
   logic [7:0]           din_b;
   logic                 cpu_hold;
   logic                 done;
   logic                 err;

   modport master (
      input  in_valid, in_data,
      output in_ready, we_b, addr_b, din_b, cpu_hold, done, err
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, we_b, addr_b, din_b, cpu_hold, done, err
   );
endinterface

// File: rtl/gamerom_loader.sv
// Game ROM loader: parses SYNC/ADDR/LEN/DATA/CSUM frames from the ESP32 stream
// and writes the payload through the ROM load port while holding the CPU.
module gamerom_loader #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         ADDR_BITS      = 16,
   parameter int         TIMEOUT_CYCLES = 1000000
) (
   input  logic           clk,
   input  logic           reset,
   gamerom_loader_if.master bus
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA, S_CSUM
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_ready;
   logic                 w_accept;
   logic                 w_timeout;
   logic                 w_sync_acc;
   logic                 w_data_acc;
   logic                 w_csum_acc;
   logic [15:0]          w_len;

   logic [7:0]           r_addr_h;
   logic [7:0]           r_len_h;
   logic [15:0]          r_count;
   logic [ADDR_BITS-1:0] r_ptr;
   logic [7:0]           r_sum;
   logic [TW-1:0]        r_timer;
   logic                 r_we;
   logic [ADDR_BITS-1:0] r_addr;
   logic [7:0]           r_din;
   logic                 r_hold;
   logic                 r_done;
   logic                 r_err;

   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      csum_add = acc + b;
   endfunction

   assign w_ready  = ~reset;
   assign w_accept = bus.in_valid & w_ready;
   assign w_len    = {r_len_h, bus.in_data};

   always_comb begin
      w_state_nxt = r_state;
      w_timeout   = 1'b0;
      w_sync_acc  = 1'b0;
      w_data_acc  = 1'b0;
      w_csum_acc  = 1'b0;
      if (w_accept) begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_data == SYNC_BYTE) begin
                  w_state_nxt = S_ADDR_H;
                  w_sync_acc  = 1'b1;
               end
            end
            S_ADDR_H: w_state_nxt = S_ADDR_L;
            S_ADDR_L: w_state_nxt = S_LEN_H;
            S_LEN_H:  w_state_nxt = S_LEN_L;
            S_LEN_L:  w_state_nxt = (w_len == 16'd0) ? S_CSUM : S_DATA;
            S_DATA: begin
               w_data_acc = 1'b1;
               if (r_count == 16'd1) w_state_nxt = S_CSUM;
            end
            S_CSUM: begin
               w_csum_acc  = 1'b1;
               w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end else if (r_state != S_IDLE && r_timer == TMAX) begin
         // A byte arriving on the deadline cycle still counts; only a true stall aborts.
         w_state_nxt = S_IDLE;
         w_timeout   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Header capture, write port and status, all registered one cycle after accept
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr_h <= 8'h00;
         r_len_h  <= 8'h00;
         r_count  <= 16'd0;
         r_ptr    <= '0;
         r_sum    <= 8'h00;
         r_timer  <= '0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_din    <= 8'h00;
         r_hold   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_we   <= w_data_acc;
         r_done <= 1'b0;

         if (r_state == S_IDLE || w_accept) r_timer <= '0;
         else                               r_timer <= r_timer + TW'(1);

         if (w_accept) begin
            case (r_state)
               S_ADDR_H: r_addr_h <= bus.in_data;
               S_ADDR_L: r_ptr    <= ADDR_BITS'({r_addr_h, bus.in_data});
               S_LEN_H:  r_len_h  <= bus.in_data;
               S_LEN_L:  r_count  <= w_len;
               default:  ;
            endcase
         end

         if (w_sync_acc) begin
            r_err  <= 1'b0;
            r_sum  <= 8'h00;
            r_hold <= 1'b1;
         end

         if (w_data_acc) begin
            r_addr  <= r_ptr;
            r_din   <= bus.in_data;
            r_ptr   <= r_ptr + ADDR_BITS'(1);
            r_sum   <= csum_add(r_sum, bus.in_data);
            r_count <= r_count - 16'd1;
         end

         if (w_csum_acc) begin
            r_hold <= 1'b0;
            if (bus.in_data == r_sum) r_done <= 1'b1;
            else                      r_err  <= 1'b1;
         end

         if (w_timeout) begin
            r_hold <= 1'b0;
            r_err  <= 1'b1;
         end
      end
   end

   assign bus.in_ready = w_ready;
   assign bus.we_b     = r_we;
   assign bus.addr_b   = r_addr;
   assign bus.din_b    = r_din;
   assign bus.cpu_hold = r_hold;
   assign bus.done     = r_done;
   assign bus.err      = r_err;
endmodule

// File: tb/tb_gamerom_loader.sv
// Directed bench for gamerom_loader: framing, checksum, wrap, LEN=0, timeout, reset mid-frame.
module tb_gamerom_loader;
   localparam int TO = 20;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   gamerom_loader_if #(.ADDR_BITS(16)) bus ();

   gamerom_loader #(
      .SYNC_BYTE(8'hA5), .ADDR_BITS(16), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt = 0;
   logic [15:0] wa_q[$];
   logic [7:0]  wd_q[$];

   always @(negedge clk) begin
      if (bus.we_b === 1'b1) begin
         wa_q.push_back(bus.addr_b);
         wd_q.push_back(bus.din_b);
      end
      if (bus.done === 1'b1) done_cnt++;
   end

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
      done_cnt = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
   endtask

   task automatic send_seq(input logic [7:0] s[$]);
      foreach (s[i]) send_byte(s[i]);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (3) @(negedge clk);
      n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.in_ready); else n_pass++;
      n_checks++; if ({bus.we_b, bus.cpu_hold, bus.done, bus.err} !== 4'b0000)
         $display("FAIL reset_ctrl: got we/hold/done/err=%b want 0000", {bus.we_b, bus.cpu_hold, bus.done, bus.err}); else n_pass++;
      n_checks++; if ({bus.addr_b, bus.din_b} !== 24'h0)
         $display("FAIL reset_bus: got addr=%h din=%h want 0000/00", bus.addr_b, bus.din_b); else n_pass++;
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", bus.in_ready); else n_pass++;
   endtask

   task automatic test_basic();
      logic [7:0] dat[3] = '{8'h11, 8'h22, 8'h33};
      clear_log();
      send_byte(8'hA5);
      n_checks++; if (bus.cpu_hold !== 1'b1) $display("FAIL basic_hold_on: got %b want 1", bus.cpu_hold); else n_pass++;
      send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
      for (int i = 0; i < 3; i++) begin
         send_byte(dat[i]);
         n_checks++;
         if (bus.we_b !== 1'b1 || bus.addr_b !== 16'h4000 + 16'(i) || bus.din_b !== dat[i])
            $display("FAIL basic_write%0d: got we=%b addr=%h din=%h want 1/%h/%h",
                     i, bus.we_b, bus.addr_b, bus.din_b, 16'h4000 + 16'(i), dat[i]);
         else n_pass++;
      end
      n_checks++; if (bus.cpu_hold !== 1'b1) $display("FAIL basic_hold_mid: got %b want 1", bus.cpu_hold); else n_pass++;
      send_byte(8'h66);
      n_checks++; if ({bus.cpu_hold, bus.done, bus.err, bus.we_b} !== 4'b0100)
         $display("FAIL basic_end: got hold/done/err/we=%b want 0100", {bus.cpu_hold, bus.done, bus.err, bus.we_b}); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", bus.done); else n_pass++;
      n_checks++; if (bus.addr_b !== 16'h4002 || bus.din_b !== 8'h33)
         $display("FAIL basic_bus_hold: got addr=%h din=%h want 4002/33", bus.addr_b, bus.din_b); else n_pass++;
      n_checks++; if (wa_q.size() != 3 || done_cnt != 1)
         $display("FAIL basic_counts: got writes=%0d done=%0d want 3/1", wa_q.size(), done_cnt); else n_pass++;
   endtask

   task automatic test_bad_csum();
      logic [7:0] f[$];
      clear_log();
      f = '{8'hA5, 8'h40, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h67};
      send_seq(f);
      repeat (2) @(negedge clk);
      n_checks++; if (bus.err !== 1'b1 || bus.cpu_hold !== 1'b0)
         $display("FAIL badcs_err: got err=%b hold=%b want 1/0", bus.err, bus.cpu_hold); else n_pass++;
      n_checks++; if (wa_q.size() != 3 || done_cnt != 0)
         $display("FAIL badcs_counts: got writes=%0d done=%0d want 3/0", wa_q.size(), done_cnt); else n_pass++;
      send_byte(8'hA5);
      n_checks++; if (bus.err !== 1'b0) $display("FAIL badcs_err_clear: got %b want 0", bus.err); else n_pass++;
      f = '{8'h40, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
      send_seq(f);
      @(negedge clk);
      n_checks++; if (done_cnt != 1 || bus.err !== 1'b0 || wa_q.size() != 6)
         $display("FAIL badcs_recover: got done=%0d err=%b writes=%0d want 1/0/6", done_cnt, bus.err, wa_q.size()); else n_pass++;
   endtask

   task automatic test_wrap();
      logic [7:0]  f[$];
      logic [15:0] ea[4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      logic [7:0]  ed[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
      clear_log();
      f = '{8'hA5, 8'hFF, 8'hFE, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
      send_seq(f);
      repeat (2) @(negedge clk);
      n_checks++; if (wa_q.size() != 4 || done_cnt != 1)
         $display("FAIL wrap_counts: got writes=%0d done=%0d want 4/1", wa_q.size(), done_cnt); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (i >= wa_q.size()) $display("FAIL wrap_write%0d: got none want %h=%h", i, ea[i], ed[i]);
         else if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i])
            $display("FAIL wrap_write%0d: got %h=%h want %h=%h", i, wa_q[i], wd_q[i], ea[i], ed[i]);
         else n_pass++;
      end
   endtask

   task automatic test_len0();
      logic [7:0] f[$];
      clear_log();
      send_byte(8'h00); send_byte(8'h12);
      n_checks++; if (bus.cpu_hold !== 1'b0) $display("FAIL len0_junk_hold: got %b want 0", bus.cpu_hold); else n_pass++;
      f = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_seq(f);
      n_checks++; if (bus.done !== 1'b1 || bus.cpu_hold !== 1'b0)
         $display("FAIL len0_done: got done=%b hold=%b want 1/0", bus.done, bus.cpu_hold); else n_pass++;
      repeat (2) @(negedge clk);
      n_checks++; if (wa_q.size() != 0 || done_cnt != 1)
         $display("FAIL len0_counts: got writes=%0d done=%0d want 0/1", wa_q.size(), done_cnt); else n_pass++;
   endtask

   task automatic test_timeout();
      logic [7:0] f[$];
      clear_log();
      f = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h05, 8'hAA, 8'hBB};
      send_seq(f);
      repeat (TO - 1) @(negedge clk);
      n_checks++; if (bus.err !== 1'b0 || bus.cpu_hold !== 1'b1)
         $display("FAIL tmo_early: got err=%b hold=%b want 0/1", bus.err, bus.cpu_hold); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.err !== 1'b1 || bus.cpu_hold !== 1'b0)
         $display("FAIL tmo_abort: got err=%b hold=%b want 1/0", bus.err, bus.cpu_hold); else n_pass++;
      repeat (5) @(negedge clk);
      n_checks++;
      if (wa_q.size() != 2) $display("FAIL tmo_writes: got %0d want 2", wa_q.size());
      else if (wa_q[0] !== 16'h1000 || wd_q[0] !== 8'hAA || wa_q[1] !== 16'h1001 || wd_q[1] !== 8'hBB)
         $display("FAIL tmo_writes: got %h=%h %h=%h want 1000=aa 1001=bb", wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
      else n_pass++;
      clear_log();
      f = '{8'hA5, 8'h20, 8'h00, 8'h00, 8'h01, 8'h5A, 8'h5A};
      send_seq(f);
      @(negedge clk);
      n_checks++;
      if (wa_q.size() != 1 || done_cnt != 1 || bus.err !== 1'b0)
         $display("FAIL tmo_recover: got writes=%0d done=%0d err=%b want 1/1/0", wa_q.size(), done_cnt, bus.err);
      else if (wa_q[0] !== 16'h2000 || wd_q[0] !== 8'h5A)
         $display("FAIL tmo_recover_data: got %h=%h want 2000=5a", wa_q[0], wd_q[0]);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [7:0] f[$];
      clear_log();
      f = '{8'hA5, 8'h30, 8'h00, 8'h00, 8'h04, 8'h01, 8'h02};
      send_seq(f);
      reset = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h03;
      @(negedge clk);
      n_checks++; if ({bus.in_ready, bus.we_b, bus.cpu_hold} !== 3'b000)
         $display("FAIL rstmid_during: got ready/we/hold=%b want 000", {bus.in_ready, bus.we_b, bus.cpu_hold}); else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      f = '{8'h04, 8'h66, 8'h30};
      send_seq(f);
      repeat (3) @(negedge clk);
      n_checks++; if (wa_q.size() != 2 || done_cnt != 0 || bus.err !== 1'b0 || bus.cpu_hold !== 1'b0)
         $display("FAIL rstmid_after: got writes=%0d done=%0d err=%b hold=%b want 2/0/0/0",
                  wa_q.size(), done_cnt, bus.err, bus.cpu_hold); else n_pass++;
   endtask

   initial begin
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      test_reset();
      test_basic();
      test_bad_csum();
      test_wrap();
      test_len0();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
